// File: rtl/vram_pkg.sv
// Shared types for the host-side video SRAM write path.
package vram_pkg;

  localparam int VRAM_ADDR_W = 18;
  localparam int VRAM_DATA_W = 16;
  localparam int VRAM_BE_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } wr_state_e;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
    logic [VRAM_BE_W-1:0]   be;
  } vram_wr_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Single-clock write-request FIFO; storage is plain registers, only pointers
// and occupancy are reset.
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  vram_wr_t               din_i,
  input  logic                   pop_i,
  output vram_wr_t               dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   avail_o
);

  localparam int PW = $clog2(DEPTH);

  vram_wr_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          fresh_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // An entry written on the previous edge is not offered for popping yet.
  assign avail_o = (count_q > {{PW{1'b0}}, fresh_q});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fresh_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fresh_q  <= push_ok;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/vram_writer.sv
// Host write port into the shared video SRAM: buffers host writes and drains
// them with a setup/strobe/hold sequence while the display side leaves the bus free.
module vram_writer
  import vram_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int WE_CYCLES = 2,
  parameter int ADDR_W    = VRAM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wrValid,
  output logic                   wrReady,
  input  logic [ADDR_W-1:0]      wrAddr,
  input  logic [VRAM_DATA_W-1:0] wrData,
  input  logic [1:0]             wrByteEn,
  input  logic                   busFree,
  output logic                   busOwn,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [VRAM_DATA_W-1:0] ram_dout,
  output logic                   ram_ce,
  output logic                   ram_oe,
  output logic                   ram_we,
  output logic                   ram_lb,
  output logic                   ram_hb,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   idle
);

  localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam int PW = $clog2(DEPTH);

  wr_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   own_q, own_d;
  logic                   ce_q, ce_d;
  logic                   we_q, we_d;
  logic                   lb_q, lb_d;
  logic                   hb_q, hb_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [VRAM_DATA_W-1:0] dout_q, dout_d;

  vram_wr_t    push_ent, head;
  logic        fifo_full, fifo_empty, fifo_avail;
  logic        pop, start;
  logic [PW:0] count;

  always_comb begin
    push_ent      = '0;
    push_ent.addr = VRAM_ADDR_W'(wrAddr);
    push_ent.data = wrData;
    push_ent.be   = wrByteEn;
  end

  vram_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .push_i  (wrValid),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .avail_o (fifo_avail)
  );

  assign start = fifo_avail && busFree;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    ce_d    = ce_q;
    we_d    = we_q;
    lb_d    = lb_q;
    hb_d    = hb_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    pop     = 1'b0;

    case (state_q)
      IDLE, HOLD: begin
        if (start) begin
          pop     = 1'b1;
          addr_d  = head.addr[ADDR_W-1:0];
          dout_d  = head.data;
          hb_d    = head.be[1];
          lb_d    = head.be[0];
          ce_d    = 1'b1;
          own_d   = 1'b1;
          we_d    = 1'b0;
          state_d = SETUP;
        end else if (state_q == HOLD) begin
          ce_d    = 1'b0;
          own_d   = 1'b0;
          lb_d    = 1'b0;
          hb_d    = 1'b0;
          state_d = IDLE;
        end
      end
      SETUP: begin
        we_d    = 1'b1;
        cnt_d   = '0;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == CW'(WE_CYCLES - 1)) begin
          we_d    = 1'b0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      own_q   <= 1'b0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      lb_q    <= 1'b0;
      hb_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      lb_q    <= lb_d;
      hb_q    <= hb_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
    end
  end

  assign wrReady  = !fifo_full;
  assign pending  = count;
  assign idle     = fifo_empty && (state_q == IDLE);
  assign busOwn   = own_q;
  assign ram_ce   = ce_q;
  assign ram_oe   = 1'b0;
  assign ram_we   = we_q;
  assign ram_lb   = lb_q;
  assign ram_hb   = hb_q;
  assign ram_addr = addr_q;
  assign ram_dout = dout_q;

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: per-cycle vector table for single writes,
// hand sequences for backpressure, bus loss, full-FIFO refill and reset.
module tb_vram_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrValid = 1'b0;
  logic [17:0] wrAddr = '0;
  logic [15:0] wrData = '0;
  logic [1:0]  wrByteEn = '0;
  logic        busFree = 1'b0;
  logic        wrReady, busOwn, ram_ce, ram_oe, ram_we, ram_lb, ram_hb, idle;
  logic [17:0] ram_addr;
  logic [15:0] ram_dout;
  logic [3:0]  pending;

  int checks = 0;
  int errors = 0;
  logic [17:0] got[$];

  vram_writer #(.DEPTH(8), .WE_CYCLES(2), .ADDR_W(18)) dut (
    .clk(clk), .rst_n(rst_n), .wrValid(wrValid), .wrReady(wrReady),
    .wrAddr(wrAddr), .wrData(wrData), .wrByteEn(wrByteEn), .busFree(busFree),
    .busOwn(busOwn), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_ce(ram_ce),
    .ram_oe(ram_oe), .ram_we(ram_we), .ram_lb(ram_lb), .ram_hb(ram_hb),
    .pending(pending), .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [17:0] a;
    logic [15:0] d;
    logic [1:0]  be;
    logic        own, ce, we, lb, hb, rdy, idl;
    logic [3:0]  pend;
    logic [17:0] ra;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outvec();
    return {18'd0, busOwn, ram_ce, ram_we, ram_lb, ram_hb, ram_oe, wrReady, idle,
            pending, ram_addr, ram_dout};
  endfunction

  function automatic logic [63:0] expvec(input vec_t e);
    return {18'd0, e.own, e.ce, e.we, e.lb, e.hb, 1'b0, e.rdy, e.idl, e.pend, e.ra, e.rd};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
    wrValid = 1'b1; wrAddr = a; wrData = d; wrByteEn = be;
    step();
    wrValid = 1'b0;
  endtask

  task automatic wait_we(input string name, input int budget);
    int n;
    n = 0;
    while (!ram_we && n < budget) begin
      step();
      n++;
    end
    check(name, 64'(ram_we), 64'd1);
  endtask

  // Steps until the writer is idle, collecting the address of every strobe.
  task automatic drain(input string name, input int budget, output int own_cnt,
                       output int we_cnt, output int gaps);
    logic prev_we, started, done;
    own_cnt = 0; we_cnt = 0; gaps = 0;
    prev_we = ram_we; started = busOwn; done = 1'b0;
    got.delete();
    for (int c = 0; c < budget; c++) begin
      step();
      if (busOwn) begin own_cnt++; started = 1'b1; end
      if (ram_we) we_cnt++;
      if (ram_we && !prev_we) got.push_back(ram_addr);
      prev_we = ram_we;
      if (idle && !busOwn) begin done = 1'b1; break; end
      if (started && !busOwn) gaps++;
    end
    check(name, 64'(done), 64'd1);
  endtask

  initial begin
    logic [17:0] wa[3];
    logic [15:0] wd[3];
    logic [1:0]  wb[3];
    logic [17:0] pa;
    logic [15:0] pd;
    int own_cnt, we_cnt, gaps, n, nxt, minp;
    logic pushing, prev_we, saw_refill, ce_seen;

    wa[0] = 18'h00040; wd[0] = 16'h1234; wb[0] = 2'b11;
    wa[1] = 18'h00100; wd[1] = 16'hABCD; wb[1] = 2'b01;
    wa[2] = 18'h00200; wd[2] = 16'h5A5A; wb[2] = 2'b00;
    pa = '0; pd = '0;
    // Timeline of one isolated write: push edge, one wait edge, SETUP, 2x STROBE, HOLD, IDLE.
    for (int w = 0; w < 3; w++) begin
      for (int p = 0; p < 7; p++) begin
        vec_t e;
        logic act;
        act    = (p >= 2) && (p <= 5);
        e.v    = (p == 0);
        e.a    = wa[w]; e.d = wd[w]; e.be = wb[w];
        e.own  = act; e.ce = act;
        e.we   = (p == 3) || (p == 4);
        e.lb   = act ? wb[w][0] : 1'b0;
        e.hb   = act ? wb[w][1] : 1'b0;
        e.rdy  = 1'b1;
        e.idl  = (p == 6);
        e.pend = (p < 2) ? 4'd1 : 4'd0;
        e.ra   = (p >= 2) ? wa[w] : pa;
        e.rd   = (p >= 2) ? wd[w] : pd;
        tbl[w*7 + p] = e;
      end
      pa = wa[w]; pd = wd[w];
    end

    #1;
    check("reset_state", outvec(), {18'd0, 8'b0000_0011, 4'd0, 18'd0, 16'd0});
    step(); step();
    rst_n = 1'b1;
    busFree = 1'b1;
    step();

    for (int i = 0; i < 21; i++) begin
      wrValid = tbl[i].v; wrAddr = tbl[i].a; wrData = tbl[i].d; wrByteEn = tbl[i].be;
      step();
      check($sformatf("vec[%0d]", i), outvec(), expvec(tbl[i]));
    end
    wrValid = 1'b0;

    // Backpressure: nine pushes while the bus is busy.
    busFree = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wrValid = 1'b1; wrAddr = 18'(32'h1000 + i); wrData = 16'(32'h1000 + i); wrByteEn = 2'b11;
      step();
      if (i == 7) begin
        check("full_ready", 64'(wrReady), 64'd0);
        check("full_pending", 64'(pending), 64'd8);
      end
    end
    wrValid = 1'b0;
    check("ninth_ignored", 64'(pending), 64'd8);
    check("no_ce_while_busy", 64'(ram_ce), 64'd0);
    busFree = 1'b1;
    drain("drain8_done", 100, own_cnt, we_cnt, gaps);
    check("drain8_count", 64'(got.size()), 64'd8);
    check("drain8_own_cycles", 64'(own_cnt), 64'd32);
    check("drain8_we_cycles", 64'(we_cnt), 64'd16);
    check("drain8_no_gap", 64'(gaps), 64'd0);
    for (int i = 0; i < got.size(); i++)
      check($sformatf("drain8_addr[%0d]", i), 64'(got[i]), 64'(32'h1000 + i));

    // Bus lost during the strobe of the first of three writes.
    for (int i = 0; i < 3; i++) push(18'(32'h2000 + i), 16'(32'h2000 + i), 2'b11);
    wait_we("abort_we_seen", 20);
    busFree = 1'b0;
    n = 0;
    while (busOwn && n < 10) begin step(); n++; end
    check("abort_released", 64'(busOwn), 64'd0);
    check("abort_cycles_to_release", 64'(n), 64'd3);
    check("abort_pending", 64'(pending), 64'd2);
    check("abort_addr", 64'(ram_addr), 64'h2000);
    ce_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); ce_seen |= ram_ce; end
    check("abort_no_new_write", 64'(ce_seen), 64'd0);
    busFree = 1'b1;
    drain("abort_drain_done", 40, own_cnt, we_cnt, gaps);
    check("abort_drain_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      check("abort_drain_addr0", 64'(got[0]), 64'h2001);
      check("abort_drain_addr1", 64'(got[1]), 64'h2002);
    end

    // Full FIFO with host still pushing while draining.
    busFree = 1'b0;
    for (int i = 0; i < 8; i++) push(18'(i), 16'(i), 2'b11);
    check("refill_start_full", 64'(pending), 64'd8);
    busFree = 1'b1;
    nxt = 8; minp = 8; saw_refill = 1'b0;
    got.delete();
    prev_we = ram_we;
    for (int c = 0; c < 200; c++) begin
      wrValid = (nxt < 12); wrAddr = 18'(nxt); wrData = 16'(nxt); wrByteEn = 2'b11;
      pushing = wrValid && wrReady;
      step();
      if (pushing) nxt++;
      if (ram_we && !prev_we) got.push_back(ram_addr);
      prev_we = ram_we;
      if (nxt < 12 && int'(pending) < minp) minp = int'(pending);
      if (got.size() > 0 && pending == 4'd8) saw_refill = 1'b1;
      if (nxt == 12 && idle) break;
    end
    wrValid = 1'b0;
    check("refill_all_pushed", 64'(nxt), 64'd12);
    check("refill_min_pending", 64'(minp), 64'd7);
    check("refill_back_to_full", 64'(saw_refill), 64'd1);
    check("refill_count", 64'(got.size()), 64'd12);
    for (int i = 0; i < got.size(); i++)
      check($sformatf("refill_addr[%0d]", i), 64'(got[i]), 64'(i));

    // Async reset in the middle of a strobe with three entries queued.
    busFree = 1'b0;
    for (int i = 0; i < 4; i++) push(18'(32'h3000 + i), 16'h7777, 2'b11);
    busFree = 1'b1;
    wait_we("rst_we_seen", 20);
    check("rst_pre_pending", 64'(pending), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_drop", 64'({ram_ce, ram_we, busOwn}), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_post_state", outvec(), {18'd0, 8'b0000_0011, 4'd0, 18'd0, 16'd0});
    ce_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); ce_seen |= ram_ce; end
    check("rst_no_write", 64'(ce_seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
